// File: rtl/sram_port_arbiter.sv
// Single-port image RAM arbiter for SPI loader, dither engine and debug query.
// Fixed priority SPI > ENG > DBG with an engine burst lock and debug anti-starvation.
//
// state | meaning
// ARB   | fixed priority SPI > ENG > DBG
// LOCK  | engine burst in progress, only ENG is granted
// FORCE | DBG granted ahead of everyone for one cycle (starvation or lock release)
module sram_port_arbiter #(
  parameter int IMAGE_ADDR_WIDTH = 16,
  parameter int RGB_SIZE         = 8,
  parameter int RD_LATENCY       = 2,
  parameter int STARVE_LIMIT     = 15
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        spi_req,
  input  logic [IMAGE_ADDR_WIDTH-1:0] spi_addr,
  input  logic [RGB_SIZE-1:0]         spi_wdata,
  output logic                        spi_gnt,
  input  logic                        eng_req,
  input  logic                        eng_we,
  input  logic                        eng_lock,
  input  logic [IMAGE_ADDR_WIDTH-1:0] eng_addr,
  input  logic [RGB_SIZE-1:0]         eng_wdata,
  output logic                        eng_gnt,
  output logic                        eng_rvalid,
  input  logic                        dbg_req,
  input  logic [IMAGE_ADDR_WIDTH-1:0] dbg_addr,
  output logic                        dbg_gnt,
  output logic                        dbg_rvalid,
  output logic [RGB_SIZE-1:0]         rdata,
  output logic [IMAGE_ADDR_WIDTH-1:0] ram_addr,
  output logic [RGB_SIZE-1:0]         ram_wdata,
  output logic                        ram_we,
  output logic                        ram_re,
  input  logic [RGB_SIZE-1:0]         ram_rdata,
  output logic [1:0]                  owner
);

  typedef enum logic [1:0] {ST_ARB, ST_LOCK, ST_FORCE} state_t;

  localparam logic [1:0] OWN_NONE   = 2'd0;
  localparam logic [1:0] OWN_SPI    = 2'd1;
  localparam logic [1:0] OWN_ENG    = 2'd2;
  localparam logic [1:0] OWN_DBG    = 2'd3;
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t     state, state_nxt;
  logic [3:0] starve_cnt;
  logic       starved;
  logic       spi_g, eng_g, dbg_g;
  logic [1:0] rd_tag;
  logic [1:0] tag_pipe [RD_LATENCY];

  assign starved = (starve_cnt == STARVE_MAX);

  // Grants are gated by rst_n so they drop immediately on reset assertion.
  always_comb begin
    spi_g     = 1'b0;
    eng_g     = 1'b0;
    dbg_g     = 1'b0;
    state_nxt = state;
    if (rst_n) begin
      if (state == ST_LOCK) begin
        eng_g = eng_req;
        if (!eng_lock) state_nxt = ST_FORCE;
      end else if (state == ST_FORCE && dbg_req) begin
        dbg_g     = 1'b1;
        state_nxt = ST_ARB;
      end else begin
        if (spi_req)      spi_g = 1'b1;
        else if (eng_req) eng_g = 1'b1;
        else if (dbg_req) dbg_g = 1'b1;
        if (starved && !dbg_g)     state_nxt = ST_FORCE;
        else if (eng_g && eng_lock) state_nxt = ST_LOCK;
        else                        state_nxt = ST_ARB;
      end
    end
  end

  assign spi_gnt = spi_g;
  assign eng_gnt = eng_g;
  assign dbg_gnt = dbg_g;
  assign owner   = spi_g ? OWN_SPI : (eng_g ? OWN_ENG : (dbg_g ? OWN_DBG : OWN_NONE));
  assign rd_tag  = (eng_g && !eng_we) ? OWN_ENG : (dbg_g ? OWN_DBG : OWN_NONE);

  // rdata is only meaningful with a valid; forcing 0 otherwise also covers reset.
  assign rdata = (eng_rvalid || dbg_rvalid) ? ram_rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_ARB;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!dbg_req || dbg_g) begin
      starve_cnt <= '0;
    end else if (!starved) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_we    <= 1'b0;
      ram_re    <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      ram_re <= 1'b0;
      if (spi_g) begin
        ram_addr  <= spi_addr;
        ram_wdata <= spi_wdata;
        ram_we    <= 1'b1;
      end else if (eng_g) begin
        ram_addr  <= eng_addr;
        ram_wdata <= eng_wdata;
        ram_we    <= eng_we;
        ram_re    <= ~eng_we;
      end else if (dbg_g) begin
        ram_addr  <= dbg_addr;
        ram_re    <= 1'b1;
      end
    end
  end

  // Owner tags travel alongside the RAM latency; clearing them on reset drops in-flight reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LATENCY; i++) tag_pipe[i] <= OWN_NONE;
      eng_rvalid <= 1'b0;
      dbg_rvalid <= 1'b0;
    end else begin
      tag_pipe[0] <= rd_tag;
      for (int i = 1; i < RD_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
      eng_rvalid <= (tag_pipe[RD_LATENCY-1] == OWN_ENG);
      dbg_rvalid <= (tag_pipe[RD_LATENCY-1] == OWN_DBG);
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed scenarios then random traffic,
// all checked every cycle against a transaction-level reference model.
module tb_sram_port_arbiter;
  localparam int AW  = 16;
  localparam int DW  = 8;
  localparam int LAT = 2;
  localparam int LIM = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          spi_req = 1'b0, eng_req = 1'b0, eng_we = 1'b0, eng_lock = 1'b0, dbg_req = 1'b0;
  logic [AW-1:0] spi_addr = '0, eng_addr = '0, dbg_addr = '0;
  logic [DW-1:0] spi_wdata = '0, eng_wdata = '0;
  logic          spi_gnt, eng_gnt, eng_rvalid, dbg_gnt, dbg_rvalid, ram_we, ram_re;
  logic [DW-1:0] rdata, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;
  logic [1:0]    owner;

  sram_port_arbiter #(
    .IMAGE_ADDR_WIDTH(AW), .RGB_SIZE(DW), .RD_LATENCY(LAT), .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .spi_req(spi_req), .spi_addr(spi_addr), .spi_wdata(spi_wdata), .spi_gnt(spi_gnt),
    .eng_req(eng_req), .eng_we(eng_we), .eng_lock(eng_lock), .eng_addr(eng_addr),
    .eng_wdata(eng_wdata), .eng_gnt(eng_gnt), .eng_rvalid(eng_rvalid),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
    .rdata(rdata), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_re(ram_re), .ram_rdata(ram_rdata), .owner(owner)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  function automatic logic [DW-1:0] init_val(logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  // RAM model: RD_LATENCY cycles from a registered ram_re to ram_rdata.
  logic [DW-1:0] ram_mem [int];
  logic [DW-1:0] rd_pipe [LAT];
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
    if (ram_re) rd_pipe[0] <= ram_mem.exists(int'(ram_addr)) ? ram_mem[int'(ram_addr)] : init_val(ram_addr);
    else        rd_pipe[0] <= '0;
    if (ram_we) ram_mem[int'(ram_addr)] = ram_wdata;
  end
  assign ram_rdata = rd_pipe[LAT-1];

  // Reference model: arbitration rules, image contents in acceptance order, return schedule.
  typedef struct {
    int            due;
    int            who;
    logic [DW-1:0] data;
  } rd_t;
  rd_t           rq[$];
  logic [DW-1:0] m_mem [int];
  bit            m_locked, m_force;
  int            m_wait;
  bit            e_we, e_re;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  bit            acc_spi, acc_eng, acc_dbg;

  function automatic logic [DW-1:0] m_read(logic [AW-1:0] a);
    if (m_mem.exists(int'(a))) return m_mem[int'(a)];
    return init_val(a);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_force = 0; m_wait = 0;
    e_we = 0; e_re = 0; e_addr = '0; e_wdata = '0;
    acc_spi = 0; acc_eng = 0; acc_dbg = 0;
    rq.delete();
  endtask

  task automatic model_cycle();
    bit gs, ge, gd, ev_e, ev_d;
    int own;
    logic [DW-1:0] ed;
    rd_t r;
    gs = 0; ge = 0; gd = 0;
    if (m_locked)                gd = 0;
    else if (m_force && dbg_req) gd = 1;
    else if (spi_req)            gs = 1;
    else if (eng_req)            ge = 1;
    else if (dbg_req)            gd = 1;
    if (m_locked) ge = eng_req;
    own = gs ? 1 : (ge ? 2 : (gd ? 3 : 0));
    chk("spi_gnt", spi_gnt, gs);
    chk("eng_gnt", eng_gnt, ge);
    chk("dbg_gnt", dbg_gnt, gd);
    chk("owner", owner, own);
    chk("ram_we", ram_we, e_we);
    chk("ram_re", ram_re, e_re);
    chk("ram_addr", ram_addr, e_addr);
    if (e_we) chk("ram_wdata", ram_wdata, e_wdata);
    ev_e = 0; ev_d = 0; ed = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      ev_e = (rq[0].who == 2);
      ev_d = (rq[0].who == 3);
      ed   = rq[0].data;
      void'(rq.pop_front());
    end
    chk("eng_rvalid", eng_rvalid, ev_e);
    chk("dbg_rvalid", dbg_rvalid, ev_d);
    if (ev_e || ev_d) chk("rdata", rdata, ed);
    if (gs) begin
      m_mem[int'(spi_addr)] = spi_wdata;
      e_we = 1; e_re = 0; e_addr = spi_addr; e_wdata = spi_wdata;
    end else if (ge) begin
      e_addr = eng_addr; e_wdata = eng_wdata; e_we = eng_we; e_re = !eng_we;
      if (eng_we) m_mem[int'(eng_addr)] = eng_wdata;
      else begin r.due = cyc + LAT + 1; r.who = 2; r.data = m_read(eng_addr); rq.push_back(r); end
    end else if (gd) begin
      e_addr = dbg_addr; e_we = 0; e_re = 1;
      r.due = cyc + LAT + 1; r.who = 3; r.data = m_read(dbg_addr); rq.push_back(r);
    end else begin
      e_we = 0; e_re = 0;
    end
    if (m_locked) begin
      m_force  = !eng_lock;
      m_locked = eng_lock;
    end else if (m_force && dbg_req) begin
      m_force = 0;
    end else begin
      m_force  = (m_wait == LIM) && !gd;
      m_locked = !m_force && ge && eng_lock;
    end
    m_wait = (dbg_req && !gd) ? ((m_wait < LIM) ? m_wait + 1 : LIM) : 0;
    acc_spi = gs; acc_eng = ge; acc_dbg = gd;
  endtask

  // One clock: check at the falling edge, advance, then requesters drop accepted requests.
  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
    cyc++;
    if (acc_spi) spi_req = 0;
    if (acc_eng) eng_req = 0;
    if (acc_dbg) dbg_req = 0;
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_gnts"}, {spi_gnt, eng_gnt, dbg_gnt}, 0);
    chk({tag, "_rvalids"}, {eng_rvalid, dbg_rvalid}, 0);
    chk({tag, "_strobes"}, {ram_we, ram_re}, 0);
    chk({tag, "_ram_addr"}, ram_addr, 0);
    chk({tag, "_ram_wdata"}, ram_wdata, 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_owner"}, owner, 0);
  endtask

  task automatic apply_reset_async();
    rst_n = 0;
    #1;
    chk_all_zero("async_reset");
    @(posedge clk);
    #1;
    rst_n = 1;
    cyc++;
    model_reset();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lock_left;
    model_reset();
    @(posedge clk); #1;
    spi_req = 1; eng_req = 1; dbg_req = 1;
    #1;
    chk_all_zero("reset_state");
    @(posedge clk); #1;
    spi_req = 0; eng_req = 0; dbg_req = 0;
    rst_n = 1;
    cyc++;

    // all three request together in ARB
    spi_req = 1; spi_addr = 16'h1234; spi_wdata = 8'h5E;
    eng_req = 1; eng_we = 0; eng_addr = 16'h0020;
    dbg_req = 1; dbg_addr = 16'h0030;
    #1;
    chk("arb_spi_only", {spi_gnt, eng_gnt, dbg_gnt}, 3'b100);
    chk("arb_owner_spi", owner, 1);
    step();
    chk("spi_ram_we", ram_we, 1);
    chk("spi_ram_addr", ram_addr, 16'h1234);
    repeat (6) step();

    // back-to-back engine reads
    eng_req = 1; eng_we = 0; eng_addr = 16'h0010;
    step();
    eng_req = 1; eng_addr = 16'h0011;
    step();
    chk("eng_rv_early", eng_rvalid, 0);
    step();
    chk("eng_rv_first", eng_rvalid, 1);
    chk("eng_rdata_first", rdata, init_val(16'h0010));
    step();
    chk("eng_rv_second", eng_rvalid, 1);
    chk("eng_rdata_second", rdata, init_val(16'h0011));
    step();
    chk("eng_rv_done", eng_rvalid, 0);

    // engine burst lock for 20 cycles with SPI and DBG waiting
    eng_req = 1; eng_lock = 1; eng_we = 1; eng_addr = 16'h0200; eng_wdata = 8'h11;
    #1;
    chk("lock_acquire", {spi_gnt, eng_gnt, dbg_gnt}, 3'b010);
    step();
    for (int i = 1; i < 20; i++) begin
      spi_req = 1; spi_addr = 16'h0300; spi_wdata = 8'h22;
      dbg_req = 1; dbg_addr = 16'h0301;
      eng_req = 1; eng_addr = AW'(16'h0200 + i); eng_wdata = DW'(i);
      #1;
      chk("lock_only_eng", {spi_gnt, eng_gnt, dbg_gnt}, 3'b010);
      step();
    end
    eng_lock = 0; eng_req = 1; eng_addr = 16'h0220;
    #1;
    chk("lock_release_eng", {spi_gnt, eng_gnt, dbg_gnt}, 3'b010);
    step();
    #1;
    chk("force_dbg_first", {spi_gnt, eng_gnt, dbg_gnt}, 3'b001);
    step();
    #1;
    chk("then_spi", {spi_gnt, eng_gnt, dbg_gnt}, 3'b100);
    step();
    repeat (4) step();

    // debug starvation under continuous SPI traffic
    for (int k = 0; k <= LIM + 1; k++) begin
      spi_req = 1; spi_addr = AW'(16'h0400 + k); spi_wdata = DW'(k);
      dbg_req = 1; dbg_addr = 16'h0050;
      #1;
      chk("starve_dbg_gnt", dbg_gnt, 32'(k == LIM + 1));
      step();
    end
    repeat (5) step();

    // reset while a debug read is in flight
    dbg_req = 1; dbg_addr = 16'h0123;
    step();
    #2;
    spi_req = 1; eng_req = 1; eng_we = 0;
    apply_reset_async();
    spi_req = 0; eng_req = 0;
    for (int k = 0; k < 6; k++) begin
      chk("no_rvalid_after_reset", dbg_rvalid, 0);
      step();
    end

    // SPI write then DBG read of the same address
    spi_req = 1; spi_addr = 16'h0100; spi_wdata = 8'hA5;
    step();
    dbg_req = 1; dbg_addr = 16'h0100;
    step();
    step();
    step();
    chk("raw_dbg_rvalid", dbg_rvalid, 1);
    chk("raw_rdata", rdata, 8'hA5);
    step();

    // random traffic on a small address window to provoke same-address hazards
    lock_left = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!spi_req && $urandom_range(0, 3) == 0) begin
        spi_req = 1; spi_addr = AW'(16'h0100 + $urandom_range(0, 15)); spi_wdata = DW'($urandom);
      end
      if (!eng_req && $urandom_range(0, 2) == 0) begin
        eng_req = 1; eng_we = 1'($urandom_range(0, 1));
        eng_addr = AW'(16'h0100 + $urandom_range(0, 15)); eng_wdata = DW'($urandom);
      end
      if (!dbg_req && $urandom_range(0, 4) == 0) begin
        dbg_req = 1; dbg_addr = AW'(16'h0100 + $urandom_range(0, 15));
      end
      if (lock_left > 0) lock_left--;
      else if ($urandom_range(0, 15) == 0) lock_left = $urandom_range(1, 8);
      eng_lock = (lock_left > 0);
      step();
    end
    eng_lock = 0;
    repeat (40) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
